ir_key_events: RTL and testbench
================================

# ir_key_events

Downstream stage of the IR remote frame decoder. Takes each decoded frame (command byte plus its complement byte), checks integrity, and tracks whether a key is held. Emits press/release events into a small FIFO that the application logic drains through a valid/ready handshake. Frames that fail the complement check are counted and discarded.

## Interface
Parameters:
- `RELEASE_CYCLES`, default 1000: idle clocks after the last valid frame before a held key is released. Range 2..2^20.
- `FIFO_DEPTH`, default 4: event FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock; every register is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `frame_valid`, in, 1: one-cycle strobe; `comando`/`comparador` are valid in that cycle.
- `comando`, in, 8: decoded command byte.
- `comparador`, in, 8: decoded complement byte.
- `ev_valid`, out, 1: the FIFO head holds an event.
- `ev_ready`, in, 1: consumer accepts the head event.
- `ev_code`, out, 8: command code of the head event.
- `ev_release`, out, 1: 0 = press, 1 = release.
- `key_held`, out, 1: a key is currently considered held.
- `held_code`, out, 8: code of the held key, or the last held key.
- `err_count`, out, 8: frames that failed the check; saturates at 255.
- `overflow`, out, 1: sticky; an event was dropped because the FIFO was full.

## Operation
- A frame is good when `comparador == ~comando`. A bad frame increments `err_count` (saturating at 255) and has no other effect.
- States: IDLE, HELD, SWAP. Timer width is `$clog2(RELEASE_CYCLES+1)`.
- IDLE, good frame with code C:
  - push press(C);
  - set `held_code` = C and `key_held` = 1;
  - load timer = RELEASE_CYCLES;
  - go to HELD.
- HELD, good frame with C == `held_code`: repeat. Reload the timer; push no event.
- HELD, good frame with C != `held_code`:
  - push release(`held_code`);
  - latch C as pending;
  - go to SWAP.
- SWAP, always exactly one cycle:
  - push press(pending);
  - set `held_code` = pending;
  - reload the timer;
  - go to HELD.
  - `frame_valid` in SWAP is ignored and not counted.
- HELD, no good frame: the timer decrements. When it reaches 0:
  - push release(`held_code`);
  - set `key_held` = 0;
  - go to IDLE.
  - `held_code` keeps its value.
- In HELD, a good same-code frame in the cycle the timer reaches 0 wins: reload, no release.
- FIFO handshake:
  - a pop occurs when `ev_valid && ev_ready`;
  - a push is accepted when the FIFO is not full, or when a pop happens in the same cycle;
  - a push that is not accepted is dropped and sets `overflow`.
  - The state machine never stalls on a full FIFO.
- Head outputs are first-word fall-through. `ev_code` and `ev_release` are stable while `ev_valid` is high and `ev_ready` is low.
- Reset mid-operation clears all state immediately, including FIFO contents. No release is emitted for a key held at reset.

## Timing
- Reset values: `ev_valid`=0, `ev_code`=0, `ev_release`=0, `key_held`=0, `held_code`=0, `err_count`=0, `overflow`=0. State = IDLE; FIFO empty.
- Press latency: good `frame_valid` at cycle N gives `ev_valid`=1 at N+1, when the FIFO was empty.
- Swap: release visible at N+1; press is written at N+1 and reaches the head after the release is popped.
- Release timeout: last good frame at N, release pushed at N+RELEASE_CYCLES, `ev_valid` at N+RELEASE_CYCLES+1 (empty FIFO).
- `key_held` and `held_code` update at the same edge as the corresponding push.
- `err_count` updates at N+1 for a bad frame at N.

## Structure
- Package `ir_pkg`:
  - state enum {IDLE, HELD, SWAP};
  - constants EV_PRESS = 1'b0 and EV_RELEASE = 1'b1;
  - event struct {release, code[7:0]};
  - ERR_MAX = 8'd255.
- Sub-module `ir_event_fifo`: parameterised depth, 9-bit entries, push/pop, full/empty flags, first-word fall-through head.
- Top level holds the checker, state machine, timer and counters.

## Test plan
- Reset, then good frame 0x45/0xBA, `ev_ready`=1 → press 0x45 at N+1; after RELEASE_CYCLES, release 0x45; `key_held` goes 1 then 0.
- Repeat 0x45 frames every RELEASE_CYCLES-1 clocks, 5 times → exactly one press; the single release comes RELEASE_CYCLES after the last frame.
- While 0x45 is held, frame 0x46/0xB9 → events in order: release 0x45, press 0x46; `held_code`=0x46.
- Bad frame 0x45/0x00 ×300 → `err_count` saturates at 255; no events; state unchanged.
- `ev_ready`=0, `FIFO_DEPTH`=4, 6 alternating-code frames → 4 events retained in order; `overflow`=1; draining yields the first 4.
- Assert `reset` low while HELD with 2 events queued → all outputs at reset values asynchronously, FIFO empty, no release after deassertion.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR key-event stage.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    SWAP
  } state_t;

  localparam logic EV_PRESS   = 1'b0;
  localparam logic EV_RELEASE = 1'b1;

  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef struct packed {
    logic       is_release;
    logic [7:0] code;
  } ev_t;

  // A frame is intact when the second byte is the bitwise complement of the first.
  function automatic logic frame_ok(input logic [7:0] cmd, input logic [7:0] cmp);
    return cmp == ~cmd;
  endfunction

endpackage

// File: rtl/ir_key_events_if.sv
// Frame input, event output handshake and status lines of the key-event stage.
interface ir_key_events_if;
  logic       frame_valid;
  logic [7:0] comando;
  logic [7:0] comparador;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_release;
  logic       key_held;
  logic [7:0] held_code;
  logic [7:0] err_count;
  logic       overflow;

  modport slave (
    input  frame_valid, comando, comparador, ev_ready,
    output ev_valid, ev_code, ev_release, key_held, held_code, err_count, overflow
  );

  modport master (
    output frame_valid, comando, comparador, ev_ready,
    input  ev_valid, ev_code, ev_release, key_held, held_code, err_count, overflow
  );
endinterface

// File: rtl/ir_event_fifo.sv
// Small first-word fall-through FIFO for 9-bit key events; head reads as zero when empty.
module ir_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [8:0] i_din,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [8:0] o_dout
);
  localparam int AW = $clog2(DEPTH);

  logic [8:0]  r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_do_pop;

  assign o_empty  = (r_wr == r_rd);
  assign o_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop = i_pop && !o_empty;
  assign o_dout   = o_empty ? 9'd0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push)   r_wr <= r_wr + 1'b1;
      if (w_do_pop) r_rd <= r_rd + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the pointers say empty.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/ir_key_events.sv
// Checks decoded IR frames, tracks the held key and queues press/release events.
module ir_key_events
  import ir_pkg::*;
#(
  parameter int RELEASE_CYCLES = 1000,
  parameter int FIFO_DEPTH     = 4
) (
  input logic            clk,
  input logic            reset,
  ir_key_events_if.slave bus
);
  localparam int            TW     = $clog2(RELEASE_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(RELEASE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(1);

  state_t      r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]  r_held_code;
  logic [7:0]  r_pending;
  logic [7:0]  r_err_count;
  logic        r_key_held;
  logic        r_overflow;

  logic        w_listen;
  logic        w_good;
  logic        w_bad;
  logic        w_same;
  logic        w_push;
  logic        w_accept;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  ev_t         w_push_ev;
  ev_t         w_head;
  logic [8:0]  w_fifo_dout;

  // Frames arriving during the one-cycle SWAP are neither acted on nor counted.
  assign w_listen = bus.frame_valid && (r_state != SWAP);
  assign w_good   = w_listen &&  frame_ok(bus.comando, bus.comparador);
  assign w_bad    = w_listen && !frame_ok(bus.comando, bus.comparador);
  assign w_same   = (bus.comando == r_held_code);

  always_comb begin
    w_push    = 1'b0;
    w_push_ev = '{is_release: EV_PRESS, code: bus.comando};
    unique case (r_state)
      IDLE: w_push = w_good;
      HELD: begin
        if (w_good) begin
          if (!w_same) begin
            w_push    = 1'b1;
            w_push_ev = '{is_release: EV_RELEASE, code: r_held_code};
          end
        end else if (r_timer == T_LAST) begin
          w_push    = 1'b1;
          w_push_ev = '{is_release: EV_RELEASE, code: r_held_code};
        end
      end
      SWAP: begin
        w_push    = 1'b1;
        w_push_ev = '{is_release: EV_PRESS, code: r_pending};
      end
      default: ;
    endcase
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop    = !w_empty && bus.ev_ready;
  assign w_accept = w_push && (!w_full || w_pop);

  ir_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_din   (w_push_ev),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_fifo_dout)
  );

  assign w_head = w_fifo_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_held_code <= '0;
      r_pending   <= '0;
      r_key_held  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_good) begin
            r_held_code <= bus.comando;
            r_key_held  <= 1'b1;
            r_timer     <= T_LOAD;
            r_state     <= HELD;
          end
        end
        HELD: begin
          // A repeat frame on the expiry cycle wins over the release.
          if (w_good) begin
            if (w_same) begin
              r_timer <= T_LOAD;
            end else begin
              r_pending <= bus.comando;
              r_state   <= SWAP;
            end
          end else if (r_timer == T_LAST) begin
            r_timer    <= '0;
            r_key_held <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        SWAP: begin
          r_held_code <= r_pending;
          r_timer     <= T_LOAD;
          r_state     <= HELD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_bad && (r_err_count != ERR_MAX)) r_err_count <= r_err_count + 1'b1;
      if (w_push && !w_accept)               r_overflow  <= 1'b1;
    end
  end

  assign bus.ev_valid   = !w_empty;
  assign bus.ev_code    = w_head.code;
  assign bus.ev_release = w_head.is_release;
  assign bus.key_held   = r_key_held;
  assign bus.held_code  = r_held_code;
  assign bus.err_count  = r_err_count;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_ir_key_events.sv
// Directed bench for ir_key_events with an event scoreboard drained at the handshake.
module tb_ir_key_events;
  import ir_pkg::*;

  localparam int RC = 20;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];

  ir_key_events_if bus ();

  ir_key_events #(
    .RELEASE_CYCLES (RC),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] p);
    bus.frame_valid = 1'b1;
    bus.comando     = c;
    bus.comparador  = p;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
  endtask

  task automatic expect_ev(input logic rel, input logic [7:0] code);
    exp_q.push_back('{is_release: rel, code: code});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ev_valid"},   bus.ev_valid,   0);
    chk({tag, "_ev_code"},    bus.ev_code,    0);
    chk({tag, "_ev_release"}, bus.ev_release, 0);
    chk({tag, "_key_held"},   bus.key_held,   0);
    chk({tag, "_held_code"},  bus.held_code,  0);
    chk({tag, "_err_count"},  bus.err_count,  0);
    chk({tag, "_overflow"},   bus.overflow,   0);
  endtask

  // Every accepted head event must match the oldest expected one.
  always @(negedge clk) begin
    ev_t e;
    if (reset && bus.ev_valid && bus.ev_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_event: observed rel=%0d code=%0h expected none",
               bus.ev_release, bus.ev_code);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("event", {23'd0, bus.ev_release, bus.ev_code}, {23'd0, e.is_release, e.code});
      end
    end
  end

  initial begin
    reset           = 1'b0;
    bus.frame_valid = 1'b0;
    bus.comando     = 8'h00;
    bus.comparador  = 8'h00;
    bus.ev_ready    = 1'b1;
    tick(3);
    chk_reset_vals("rst");
    reset = 1'b1;
    tick(2);

    // Single press then timeout release
    expect_ev(EV_PRESS, 8'h45);
    frame(8'h45, 8'hBA);
    chk("press_valid", bus.ev_valid, 1);
    chk("press_code", bus.ev_code, 8'h45);
    chk("press_held", bus.key_held, 1);
    chk("press_held_code", bus.held_code, 8'h45);
    expect_ev(EV_RELEASE, 8'h45);
    tick(RC - 1);
    chk("pre_timeout_held", bus.key_held, 1);
    chk("pre_timeout_valid", bus.ev_valid, 0);
    tick(1);
    chk("timeout_held", bus.key_held, 0);
    chk("timeout_valid", bus.ev_valid, 1);
    chk("timeout_rel", bus.ev_release, 1);
    chk("timeout_held_code", bus.held_code, 8'h45);
    tick(2);

    // Repeats every RC-1 clocks keep the key held with one press
    expect_ev(EV_PRESS, 8'h45);
    frame(8'h45, 8'hBA);
    for (int i = 0; i < 4; i++) begin
      tick(RC - 2);
      frame(8'h45, 8'hBA);
    end
    expect_ev(EV_RELEASE, 8'h45);
    tick(RC - 1);
    chk("repeat_still_held", bus.key_held, 1);
    chk("repeat_pending", exp_q.size(), 1);
    tick(1);
    chk("repeat_released", bus.key_held, 0);
    chk("repeat_rel_valid", bus.ev_valid, 1);
    tick(2);

    // Code change: release old, press new
    expect_ev(EV_PRESS, 8'h45);
    frame(8'h45, 8'hBA);
    tick(3);
    expect_ev(EV_RELEASE, 8'h45);
    expect_ev(EV_PRESS, 8'h46);
    frame(8'h46, 8'hB9);
    chk("swap_rel_head", {bus.ev_release, bus.ev_code}, {1'b1, 8'h45});
    chk("swap_old_code", bus.held_code, 8'h45);
    tick(1);
    chk("swap_new_code", bus.held_code, 8'h46);
    chk("swap_press_head", {bus.ev_release, bus.ev_code}, {1'b0, 8'h46});
    chk("swap_held", bus.key_held, 1);
    expect_ev(EV_RELEASE, 8'h46);
    tick(RC);
    chk("swap_timeout", bus.key_held, 0);
    tick(2);

    // Bad frames count and saturate without side effects
    bus.comando     = 8'h45;
    bus.comparador  = 8'h00;
    bus.frame_valid = 1'b1;
    tick(10);
    chk("err_10", bus.err_count, 10);
    tick(290);
    bus.frame_valid = 1'b0;
    tick(1);
    chk("err_sat", bus.err_count, 255);
    chk("err_no_held", bus.key_held, 0);
    chk("err_no_event", bus.ev_valid, 0);
    chk("err_held_code", bus.held_code, 8'h46);

    // Stalled consumer: first four events retained, rest dropped
    bus.ev_ready = 1'b0;
    expect_ev(EV_PRESS, 8'h10);
    expect_ev(EV_RELEASE, 8'h10);
    expect_ev(EV_PRESS, 8'h20);
    expect_ev(EV_RELEASE, 8'h20);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) frame(8'h10, 8'hEF);
      else            frame(8'h20, 8'hDF);
      tick(1);
    end
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_valid", bus.ev_valid, 1);
    chk("ovf_head", {bus.ev_release, bus.ev_code}, {1'b0, 8'h10});
    chk("ovf_held_code", bus.held_code, 8'h20);
    tick(3);
    chk("ovf_head_stable", {bus.ev_release, bus.ev_code}, {1'b0, 8'h10});
    expect_ev(EV_RELEASE, 8'h20);
    bus.ev_ready = 1'b1;
    tick(RC + 2);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_released", bus.key_held, 0);
    chk("ovf_sticky", bus.overflow, 1);
    chk("ovf_empty", bus.ev_valid, 0);

    // Reset while held with events queued
    bus.ev_ready = 1'b0;
    expect_ev(EV_PRESS, 8'h30);
    frame(8'h30, 8'hCF);
    tick(1);
    frame(8'h40, 8'hBF);
    tick(1);
    bus.ev_ready = 1'b1;
    tick(1);
    bus.ev_ready = 1'b0;
    chk("mid_head", {bus.ev_release, bus.ev_code}, {1'b1, 8'h30});
    chk("mid_held", bus.key_held, 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    tick(2);
    reset = 1'b1;
    bus.ev_ready = 1'b1;
    tick(RC + 5);
    chk("post_rst_valid", bus.ev_valid, 0);
    chk("post_rst_held", bus.key_held, 0);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
